// File: rtl/cache_pkg.sv
// Shared definitions for the two-cache snoopy system: bus widths, request
// codes on the cache memory ports and the memory controller state encoding.
package cache_pkg;

    localparam int ADDRWIDTH    = 16;
    localparam int WORDWIDTH    = 16;
    localparam int IOSTATEWIDTH = 2;

    // Request code driven by a cache on memRW; code 3 is not a legal request
    typedef enum logic [IOSTATEWIDTH-1:0] {
        RD      = 2'd0,
        WT      = 2'd1,
        IDEL    = 2'd2,
        ILLEGAL = 2'd3
    } io_state_e;

    // Memory controller sequencing
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } ctrl_state_e;

    // True when a port code asks for a memory access
    function automatic logic is_req(input logic [IOSTATEWIDTH-1:0] code);
        return (code == RD) || (code == WT);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_mem_array.sv
// Single-port synchronous RAM with registered read. Contents are not reset;
// rdata only changes on a read so it can be sampled a cycle later.
module mem_array #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port share one address
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory side of the two-cache system: round-robin arbiter between the two
// cache memory ports, a fixed-latency access sequencer over mem_array, and
// per-port response registers with one-cycle done pulses.
module mem_bus_ctrl #(
    parameter int ADDRWIDTH = cache_pkg::ADDRWIDTH,
    parameter int WORDWIDTH = cache_pkg::WORDWIDTH,
    parameter int MEM_AW    = 8,
    parameter int MEM_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           memRW0,
    input  logic [1:0]           memRW1,
    input  logic [ADDRWIDTH-1:0] addrToMem0,
    input  logic [ADDRWIDTH-1:0] addrToMem1,
    input  logic [WORDWIDTH-1:0] dataToMem0,
    input  logic [WORDWIDTH-1:0] dataToMem1,
    output logic [ADDRWIDTH-1:0] addrFromMem0,
    output logic [ADDRWIDTH-1:0] addrFromMem1,
    output logic [WORDWIDTH-1:0] dataFromMem0,
    output logic [WORDWIDTH-1:0] dataFromMem1,
    output logic                 memReadEn0,
    output logic                 memReadEn1,
    output logic                 memWriteDone0,
    output logic                 memWriteDone1,
    output logic                 busy,
    output logic                 busErr
);
    import cache_pkg::*;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    ctrl_state_e                      state_q, state_d;
    logic                             rr_q, rr_d;
    logic [3:0]                       cnt_q, cnt_d;
    logic                             gid_q, gid_d;
    logic                             op_wt_q, op_wt_d;
    logic [ADDRWIDTH-1:0]             faddr_q, faddr_d;
    logic [WORDWIDTH-1:0]             wdata_q, wdata_d;
    logic [1:0][ADDRWIDTH-1:0]        aout_q, aout_d;
    logic [1:0][WORDWIDTH-1:0]        dhold_q, dhold_d;
    logic [1:0]                       rd_en_q, rd_en_d;
    logic [1:0]                       wr_done_q, wr_done_d;
    logic                             busy_q, busy_d;
    logic                             err_q, err_d;

    logic                             req0, req1, sel;
    logic                             ram_we, ram_re;
    logic [WORDWIDTH-1:0]             ram_rdata;

    // Next-state: grant in IDLE, count down in ACCESS, deliver response in RESP
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        gid_d     = gid_q;
        op_wt_d   = op_wt_q;
        faddr_d   = faddr_q;
        wdata_d   = wdata_q;
        aout_d    = aout_q;
        dhold_d   = dhold_q;
        rd_en_d   = '0;
        wr_done_d = '0;
        busy_d    = busy_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        req0      = is_req(memRW0);
        req1      = is_req(memRW1);
        sel       = 1'b0;
        case (state_q)
            IDLE: begin
                // An illegal code is flagged and otherwise behaves like IDEL
                if (memRW0 == ILLEGAL || memRW1 == ILLEGAL) err_d = 1'b1;
                if (req0 || req1) begin
                    sel     = (req0 && req1) ? rr_q : req1;
                    gid_d   = sel;
                    op_wt_d = sel ? (memRW1 == WT) : (memRW0 == WT);
                    faddr_d = sel ? addrToMem1 : addrToMem0;
                    wdata_d = sel ? dataToMem1 : dataToMem0;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // RAM is touched on the edge into RESP; pulses go high with it
                    ram_we = op_wt_q;
                    ram_re = ~op_wt_q;
                    if (op_wt_q) wr_done_d[gid_q] = 1'b1;
                    else         rd_en_d[gid_q]   = 1'b1;
                    aout_d[gid_q] = faddr_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Keep the read word for this port until its next read
                if (!op_wt_q) dhold_d[gid_q] = ram_rdata;
                rr_d    = ~gid_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            gid_q     <= 1'b0;
            op_wt_q   <= 1'b0;
            faddr_q   <= '0;
            wdata_q   <= '0;
            aout_q    <= '0;
            dhold_q   <= '0;
            rd_en_q   <= '0;
            wr_done_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            gid_q     <= gid_d;
            op_wt_q   <= op_wt_d;
            faddr_q   <= faddr_d;
            wdata_q   <= wdata_d;
            aout_q    <= aout_d;
            dhold_q   <= dhold_d;
            rd_en_q   <= rd_en_d;
            wr_done_q <= wr_done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    mem_array #(
        .AW (MEM_AW),
        .DW (WORDWIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (faddr_q[MEM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // During the read pulse the fresh RAM word is shown; afterwards the held copy
    assign dataFromMem0  = rd_en_q[0] ? ram_rdata : dhold_q[0];
    assign dataFromMem1  = rd_en_q[1] ? ram_rdata : dhold_q[1];
    assign addrFromMem0  = aout_q[0];
    assign addrFromMem1  = aout_q[1];
    assign memReadEn0    = rd_en_q[0];
    assign memReadEn1    = rd_en_q[1];
    assign memWriteDone0 = wr_done_q[0];
    assign memWriteDone1 = wr_done_q[1];
    assign busy          = busy_q;
    assign busErr        = err_q;

endmodule
